// File: rtl/fft_twiddle_mult_stage_pkg.sv
// Shared constants and helpers for the radix-R twiddle-multiply stage.
// Twiddles are fixed point with +1.0 represented as 2^(W_BIT-2).
package fft_twiddle_mult_stage_pkg;

    localparam int unsigned D_BIT_DEF = 17;
    localparam int unsigned W_BIT_DEF = 12;
    localparam int unsigned RADIX_DEF = 4;
    localparam int unsigned STAGE_LAT = 3;

    function automatic int unsigned twiddle_unity(input int unsigned w_bit);
        return 32'd1 << (w_bit - 2);
    endfunction

    // Half an LSB of the post-shift result, for round-half-up.
    function automatic int unsigned round_bias(input int unsigned w_bit);
        return 32'd1 << (w_bit - 3);
    endfunction

endpackage

// File: rtl/fft_twiddle_mult_stage_cmult.sv
// One complex-multiply lane: S1 input register, S2 partial products, S3 add/round/saturate.
// oSAT reports saturation of the value S3 is about to capture, already qualified by its valid tag.
module fft_cmult_pipe
    import fft_twiddle_mult_stage_pkg::*;
#(
    parameter int unsigned D_BIT = D_BIT_DEF,
    parameter int unsigned W_BIT = W_BIT_DEF
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iCE,
    input  logic                    iVALID,
    input  logic                    iINV,
    input  logic signed [D_BIT-1:0] iX_RE,
    input  logic signed [D_BIT-1:0] iX_IM,
    input  logic signed [W_BIT-1:0] iW_RE,
    input  logic signed [W_BIT-1:0] iW_IM,
    output logic                    oVALID,
    output logic signed [D_BIT-1:0] oY_RE,
    output logic signed [D_BIT-1:0] oY_IM,
    output logic                    oSAT
);

    localparam int unsigned ACC_W = D_BIT + W_BIT + 2;
    localparam int unsigned SHIFT = $clog2(twiddle_unity(W_BIT));
    localparam logic signed [ACC_W-1:0] RND   = ACC_W'(round_bias(W_BIT));
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-D_BIT+1){1'b0}}, {(D_BIT-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-D_BIT+1){1'b1}}, {(D_BIT-1){1'b0}}};

    logic                    r_v1, r_inv1, r_v2, r_v3;
    logic signed [D_BIT-1:0] r_xr1, r_xi1;
    logic signed [W_BIT-1:0] r_wr1, r_wi1;
    logic signed [ACC_W-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
    logic signed [D_BIT-1:0] r_y_re, r_y_im;

    logic signed [W_BIT:0]   w_wr_ext, w_wi_ext, w_wi_eff;
    logic signed [ACC_W-1:0] w_re_sum, w_im_sum, w_re_rnd, w_im_rnd;
    logic                    w_re_hi, w_re_lo, w_im_hi, w_im_lo;
    logic signed [D_BIT-1:0] w_re_y, w_im_y;

    // One extra bit so negating the most negative twiddle stays exact.
    assign w_wr_ext = {r_wr1[W_BIT-1], r_wr1};
    assign w_wi_ext = {r_wi1[W_BIT-1], r_wi1};
    assign w_wi_eff = r_inv1 ? -w_wi_ext : w_wi_ext;

    assign w_re_sum = r_p_rr - r_p_ii;
    assign w_im_sum = r_p_ri + r_p_ir;
    assign w_re_rnd = (w_re_sum + RND) >>> SHIFT;
    assign w_im_rnd = (w_im_sum + RND) >>> SHIFT;

    always_comb begin
        w_re_hi = w_re_rnd > Y_MAX;
        w_re_lo = w_re_rnd < Y_MIN;
        w_im_hi = w_im_rnd > Y_MAX;
        w_im_lo = w_im_rnd < Y_MIN;
        w_re_y  = w_re_rnd[D_BIT-1:0];
        w_im_y  = w_im_rnd[D_BIT-1:0];
        if (w_re_hi) w_re_y = Y_MAX[D_BIT-1:0];
        if (w_re_lo) w_re_y = Y_MIN[D_BIT-1:0];
        if (w_im_hi) w_im_y = Y_MAX[D_BIT-1:0];
        if (w_im_lo) w_im_y = Y_MIN[D_BIT-1:0];
    end

    assign oSAT = r_v2 & (w_re_hi | w_re_lo | w_im_hi | w_im_lo);

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            r_v1   <= 1'b0;
            r_inv1 <= 1'b0;
            r_xr1  <= '0;
            r_xi1  <= '0;
            r_wr1  <= '0;
            r_wi1  <= '0;
            r_v2   <= 1'b0;
            r_p_rr <= '0;
            r_p_ii <= '0;
            r_p_ri <= '0;
            r_p_ir <= '0;
            r_v3   <= 1'b0;
            r_y_re <= '0;
            r_y_im <= '0;
        end else if (iCE) begin
            r_v1   <= iVALID;
            r_inv1 <= iINV;
            r_xr1  <= iX_RE;
            r_xi1  <= iX_IM;
            r_wr1  <= iW_RE;
            r_wi1  <= iW_IM;
            r_v2   <= r_v1;
            r_p_rr <= ACC_W'(r_xr1) * ACC_W'(w_wr_ext);
            r_p_ii <= ACC_W'(r_xi1) * ACC_W'(w_wi_eff);
            r_p_ri <= ACC_W'(r_xr1) * ACC_W'(w_wi_eff);
            r_p_ir <= ACC_W'(r_xi1) * ACC_W'(w_wr_ext);
            r_v3   <= r_v2;
            r_y_re <= w_re_y;
            r_y_im <= w_im_y;
        end
    end

    assign oVALID = r_v3;
    assign oY_RE  = r_y_re;
    assign oY_IM  = r_y_im;

endmodule

// File: rtl/fft_twiddle_mult_stage.sv
// Radix-R twiddle-multiply stage: lane 0 is delayed only, lanes 1..R-1 each use a fft_cmult_pipe.
// Holds the sticky saturation flag; clear acts regardless of the pipeline enable.
module fft_twiddle_mult_stage
    import fft_twiddle_mult_stage_pkg::*;
#(
    parameter int unsigned D_BIT = D_BIT_DEF,
    parameter int unsigned W_BIT = W_BIT_DEF,
    parameter int unsigned RADIX = RADIX_DEF
) (
    input  logic                       iCLK,
    input  logic                       iRESET,
    input  logic                       iCE,
    input  logic                       iVALID,
    input  logic                       iINV,
    input  logic [RADIX*D_BIT-1:0]     iX_RE,
    input  logic [RADIX*D_BIT-1:0]     iX_IM,
    input  logic [(RADIX-1)*W_BIT-1:0] iW_RE,
    input  logic [(RADIX-1)*W_BIT-1:0] iW_IM,
    input  logic                       iOVF_CLR,
    output logic                       oVALID,
    output logic [RADIX*D_BIT-1:0]     oY_RE,
    output logic [RADIX*D_BIT-1:0]     oY_IM,
    output logic                       oOVF
);

    logic [D_BIT-1:0] r_d0_re [STAGE_LAT];
    logic [D_BIT-1:0] r_d0_im [STAGE_LAT];
    logic             r_ovf;
    logic [RADIX-1:1] w_lane_valid;
    logic [RADIX-1:1] w_lane_sat;

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            for (int unsigned i = 0; i < STAGE_LAT; i++) begin
                r_d0_re[i] <= '0;
                r_d0_im[i] <= '0;
            end
        end else if (iCE) begin
            r_d0_re[0] <= iX_RE[D_BIT-1:0];
            r_d0_im[0] <= iX_IM[D_BIT-1:0];
            for (int unsigned i = 1; i < STAGE_LAT; i++) begin
                r_d0_re[i] <= r_d0_re[i-1];
                r_d0_im[i] <= r_d0_im[i-1];
            end
        end
    end

    assign oY_RE[D_BIT-1:0] = r_d0_re[STAGE_LAT-1];
    assign oY_IM[D_BIT-1:0] = r_d0_im[STAGE_LAT-1];

    for (genvar k = 1; k < RADIX; k++) begin : g_lane
        fft_cmult_pipe #(
            .D_BIT(D_BIT),
            .W_BIT(W_BIT)
        ) u_cmult (
            .iCLK   (iCLK),
            .iRESET (iRESET),
            .iCE    (iCE),
            .iVALID (iVALID),
            .iINV   (iINV),
            .iX_RE  (iX_RE[k*D_BIT +: D_BIT]),
            .iX_IM  (iX_IM[k*D_BIT +: D_BIT]),
            .iW_RE  (iW_RE[(k-1)*W_BIT +: W_BIT]),
            .iW_IM  (iW_IM[(k-1)*W_BIT +: W_BIT]),
            .oVALID (w_lane_valid[k]),
            .oY_RE  (oY_RE[k*D_BIT +: D_BIT]),
            .oY_IM  (oY_IM[k*D_BIT +: D_BIT]),
            .oSAT   (w_lane_sat[k])
        );
    end

    // All lanes carry identical valid tags; lane 0 needs none of its own.
    assign oVALID = &w_lane_valid;

    // Set takes priority over clear when both land on the same edge.
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            r_ovf <= 1'b0;
        end else if (iCE && (|w_lane_sat)) begin
            r_ovf <= 1'b1;
        end else if (iOVF_CLR) begin
            r_ovf <= 1'b0;
        end
    end

    assign oOVF = r_ovf;

endmodule

// File: tb/tb_fft_twiddle_mult_stage.sv
// Scoreboard bench for fft_twiddle_mult_stage (D_BIT=17, W_BIT=12, RADIX=4).
module tb_fft_twiddle_mult_stage;

    localparam int D = 17;
    localparam int W = 12;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;
    logic vld = 1'b0;
    logic inv = 1'b0;
    logic ovf_clr = 1'b0;
    logic [R*D-1:0]     x_re = '0;
    logic [R*D-1:0]     x_im = '0;
    logic [(R-1)*W-1:0] w_re = '0;
    logic [(R-1)*W-1:0] w_im = '0;
    logic               o_valid;
    logic [R*D-1:0]     y_re;
    logic [R*D-1:0]     y_im;
    logic               o_ovf;

    typedef struct {
        logic [R*D-1:0] re;
        logic [R*D-1:0] im;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;
    int   n_out = 0;
    logic adv = 1'b0;

    fft_twiddle_mult_stage #(
        .D_BIT(D),
        .W_BIT(W),
        .RADIX(R)
    ) dut (
        .iCLK     (clk),
        .iRESET   (rst_n),
        .iCE      (ce),
        .iVALID   (vld),
        .iINV     (inv),
        .iX_RE    (x_re),
        .iX_IM    (x_im),
        .iW_RE    (w_re),
        .iW_IM    (w_im),
        .iOVF_CLR (ovf_clr),
        .oVALID   (o_valid),
        .oY_RE    (y_re),
        .oY_IM    (y_im),
        .oOVF     (o_ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [R*D-1:0] xrv, input logic [R*D-1:0] xiv,
                                   input logic [(R-1)*W-1:0] wrv, input logic [(R-1)*W-1:0] wiv,
                                   input logic inv_i);
        exp_t e;
        longint xr, xi, wr, wi, re, im;
        e.re = '0;
        e.im = '0;
        e.re[D-1:0] = xrv[D-1:0];
        e.im[D-1:0] = xiv[D-1:0];
        for (int k = 1; k < R; k++) begin
            xr = longint'($signed(xrv[k*D +: D]));
            xi = longint'($signed(xiv[k*D +: D]));
            wr = longint'($signed(wrv[(k-1)*W +: W]));
            wi = longint'($signed(wiv[(k-1)*W +: W]));
            if (inv_i) wi = -wi;
            re = (xr * wr - xi * wi + 512) >>> 10;
            im = (xr * wi + xi * wr + 512) >>> 10;
            if (re > 65535) re = 65535; else if (re < -65536) re = -65536;
            if (im > 65535) im = 65535; else if (im < -65536) im = -65536;
            e.re[k*D +: D] = re[D-1:0];
            e.im[k*D +: D] = im[D-1:0];
        end
        return e;
    endfunction

    // Output register only moves on an enabled, non-reset edge.
    always @(posedge clk) adv <= ce && rst_n;

    always @(negedge clk) begin
        if (adv && o_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected oVALID=1 with empty scoreboard, required no output");
            end else begin
                last_exp = sb.pop_front();
                n_out++;
                if (y_re !== last_exp.re || y_im !== last_exp.im) begin
                    errors++;
                    $display("FAIL sb_data got re=%h im=%h required re=%h im=%h",
                             y_re, y_im, last_exp.re, last_exp.im);
                end
            end
        end
    end

    task automatic set_lane(input int k, input int xr, input int xi, input int wr, input int wi);
        x_re[k*D +: D] = xr[D-1:0];
        x_im[k*D +: D] = xi[D-1:0];
        if (k > 0) begin
            w_re[(k-1)*W +: W] = wr[W-1:0];
            w_im[(k-1)*W +: W] = wi[W-1:0];
        end
    endtask

    task automatic rand_lanes();
        for (int k = 0; k < R; k++)
            set_lane(k, int'($urandom_range(0, 131071)), int'($urandom_range(0, 131071)),
                     int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
    endtask

    task automatic send(input logic inv_i);
        vld = 1'b1;
        inv = inv_i;
        if (ce && rst_n) sb.push_back(model(x_re, x_im, w_re, w_im, inv_i));
        @(posedge clk);
        #1;
        vld = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ce = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            rand_lanes();
            vld = 1'($urandom_range(0, 1));
            inv = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0 || y_re !== '0 || y_im !== '0 || o_ovf !== 1'b0) begin
                errors++;
                $display("FAIL reset_state got v=%b re=%h im=%h ovf=%b required all zero",
                         o_valid, y_re, y_im, o_ovf);
            end
            @(posedge clk);
            #1;
        end
        vld = 1'b0;
        inv = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_identity();
        int  lat;
        bit  found;
        set_lane(0, 7, 8, 0, 0);
        set_lane(1, 1000, -500, 1024, 0);
        set_lane(2, -1234, 77, 1024, 0);
        set_lane(3, 0, 0, 1024, 0);
        send(1'b0);
        lat = 1;
        found = 0;
        while (lat < 12 && !found) begin
            @(negedge clk);
            #1;
            if (o_valid === 1'b1) found = 1;
            else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        checks++;
        if (!found || lat != 3) begin
            errors++;
            $display("FAIL identity_latency got %0d (found=%0d) required 3", lat, found);
        end
        checks++;
        if (y_re[D-1:0] !== 17'd7 || y_im[D-1:0] !== 17'd8 ||
            y_re[2*D-1:D] !== 17'd1000 || y_im[2*D-1:D] !== 17'(-500)) begin
            errors++;
            $display("FAIL identity_data got y0=%h+%hj y1=%h+%hj required 7+8j 1000-500j",
                     y_re[D-1:0], y_im[D-1:0], y_re[2*D-1:D], y_im[2*D-1:D]);
        end
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL identity_drain got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_rotation();
        set_lane(0, 5, 6, 0, 0);
        set_lane(1, 100, 200, 0, -1024);
        set_lane(2, 100, 200, 0, -1024);
        set_lane(3, 100, 0, 0, -2048);
        send(1'b0);
        send(1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (y_re[2*D-1:D] !== 17'd200 || y_im[2*D-1:D] !== 17'(-100) || y_im[4*D-1:3*D] !== 17'(-200)) begin
            errors++;
            $display("FAIL rotation_fwd got y1=%h+%hj y3im=%h required 200-100j y3im=-200",
                     y_re[2*D-1:D], y_im[2*D-1:D], y_im[4*D-1:3*D]);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (y_re[2*D-1:D] !== 17'(-200) || y_im[2*D-1:D] !== 17'd100 || y_im[4*D-1:3*D] !== 17'd200) begin
            errors++;
            $display("FAIL rotation_inv got y1=%h+%hj y3im=%h required -200+100j y3im=200",
                     y_re[2*D-1:D], y_im[2*D-1:D], y_im[4*D-1:3*D]);
        end
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rotation_drain got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_rounding();
        set_lane(0, 0, 0, 0, 0);
        set_lane(1, 3, 0, 512, 0);
        set_lane(2, -3, 0, 512, 0);
        set_lane(3, 1, 0, 512, 0);
        send(1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (y_re[2*D-1:D] !== 17'd2 || y_re[3*D-1:2*D] !== 17'(-1) || y_re[4*D-1:3*D] !== 17'd1) begin
            errors++;
            $display("FAIL rounding got %h %h %h required 2 -1 1",
                     y_re[2*D-1:D], y_re[3*D-1:2*D], y_re[4*D-1:3*D]);
        end
        drain();
    endtask

    task automatic test_saturation();
        set_lane(0, 0, 0, 0, 0);
        set_lane(1, 65535, 65535, 1024, -1024);
        set_lane(2, -65536, -65536, 1024, 1024);
        set_lane(3, 1000, 0, 1024, 0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_invalid got %b required 0", o_ovf);
        end
        send(1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (o_ovf !== 1'b1 || y_re[2*D-1:D] !== 17'd65535 || y_im[2*D-1:D] !== 17'd0 ||
            y_im[3*D-1:2*D] !== 17'h10000) begin
            errors++;
            $display("FAIL sat_data got ovf=%b y1=%h+%hj y2im=%h required 1 65535+0j -65536",
                     o_ovf, y_re[2*D-1:D], y_im[2*D-1:D], y_im[3*D-1:2*D]);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (o_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b required 1", o_ovf);
        end
        ce = 1'b0;
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        ce = 1'b1;
        checks++;
        if (o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr_stalled got %b required 0", o_ovf);
        end
        send(1'b0);
        @(posedge clk);
        #1;
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        checks++;
        if (o_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins got %b required 1", o_ovf);
        end
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        checks++;
        if (o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr got %b required 0", o_ovf);
        end
        drain();
    endtask

    task automatic test_stall();
        int base;
        base = n_out;
        for (int i = 0; i < 4; i++) begin
            rand_lanes();
            send(1'($urandom_range(0, 1)));
        end
        ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (o_valid !== 1'b1 || y_re !== last_exp.re || y_im !== last_exp.im) begin
                errors++;
                $display("FAIL stall_hold got v=%b re=%h required v=1 re=%h", o_valid, y_re, last_exp.re);
            end
            @(posedge clk);
            #1;
            rand_lanes();
            vld = 1'b1;
        end
        vld = 1'b0;
        ce = 1'b1;
        rand_lanes();
        send(1'b0);
        drain();
        checks++;
        if (n_out - base != 5 || sb.size() != 0) begin
            errors++;
            $display("FAIL stall_count got %0d outputs %0d pending required 5 and 0", n_out - base, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = n_out;
        for (int i = 0; i < 10; i++) begin
            rand_lanes();
            send(1'($urandom_range(0, 1)));
        end
        drain();
        checks++;
        if (n_out - base != 10 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_count got %0d outputs %0d pending required 10 and 0", n_out - base, sb.size());
        end
    endtask

    task automatic test_reset_midstream();
        rand_lanes();
        send(1'b0);
        rand_lanes();
        send(1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0 || o_ovf !== 1'b0) begin
                errors++;
                $display("FAIL reset_flush got v=%b ovf=%b required 0 0", o_valid, o_ovf);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_rotation();
        test_rounding();
        test_saturation();
        test_stall();
        test_back_to_back();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
